// File: rtl/bus_slave_decoder.sv
// Address decoder/responder: one bus master to SLAVES slaves with a registered request stage. Mapped access: o_ready 1 cycle after the slave's ready, 2 cycles minimum; unmapped access: o_ready + o_error 1 cycle after the request.
// Backpressure: the master holds i_request until o_ready and drops it before the next access. Optional stall abort with BUS_DECODER_TIMEOUT_EN.
module bus_slave_decoder #(
    parameter int                            SLAVES      = 4,
    parameter int                            DECODE_BITS = 4,
    parameter logic [SLAVES*DECODE_BITS-1:0] MAP         = {4'h4, 4'h3, 4'h1, 4'h0},
`ifdef BUS_DECODER_TIMEOUT_EN
    parameter int                            TIMEOUT     = 1024,
`endif
    parameter logic [31:0]                   ERROR_DATA  = 32'hDEADBEEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_request,
    input  logic                 i_rw,
    input  logic [31:0]          i_address,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata,
    output logic                 o_ready,
    output logic                 o_error,
    output logic [SLAVES-1:0]    o_s_request,
    output logic                 o_s_rw,
    output logic [31:0]          o_s_address,
    output logic [31:0]          o_s_wdata,
    input  logic [SLAVES*32-1:0] i_s_rdata,
    input  logic [SLAVES-1:0]    i_s_ready,
    output logic [31:0]          o_error_address,
    output logic [15:0]          o_error_count
);

    localparam int          SEL_W     = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> DECODE_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE,
        S_ERROR,
        S_RELEASE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_rw;
    logic [31:0]       r_address;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [SEL_W-1:0]  r_sel;
    logic [31:0]       r_error_address;
    logic [15:0]       r_error_count;

    logic [DECODE_BITS-1:0] w_region;
    logic                   w_hit;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_sel_rdy;
    logic                   w_expire;
    logic [31:0]            w_s_rdata [SLAVES];

    assign w_region = i_address[31 -: DECODE_BITS];

    for (genvar g = 0; g < SLAVES; g++) begin : g_rdata
        assign w_s_rdata[g] = i_s_rdata[32*g +: 32];
    end

    // Scan downwards so the lowest matching slave wins on duplicate map entries.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = SLAVES - 1; k >= 0; k--) begin
            if (MAP[k*DECODE_BITS +: DECODE_BITS] == w_region) begin
                w_hit = 1'b1;
                w_sel = SEL_W'(k);
            end
        end
    end

    assign w_sel_rdy = i_s_ready[r_sel];

`ifdef BUS_DECODER_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_wait;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wait <= '0;
        end else if (r_state == S_IDLE) begin
            r_wait <= '0;
        end else if (r_state == S_ACTIVE && !w_sel_rdy) begin
            r_wait <= r_wait + 16'd1;
        end
    end

    assign w_expire = (r_wait == WAIT_LAST);
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_request) begin
                    w_next = w_hit ? S_ACTIVE : S_ERROR;
                end
            end
            S_ACTIVE: begin
                // A ready arriving on the expiry cycle still completes normally.
                if (w_sel_rdy) begin
                    w_next = S_DONE;
                end else if (w_expire) begin
                    w_next = S_ERROR;
                end
            end
            S_DONE:    w_next = S_RELEASE;
            S_ERROR:   w_next = S_RELEASE;
            S_RELEASE: begin
                if (!i_request) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rw      <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_rdata   <= '0;
        end else begin
            if (r_state == S_IDLE && i_request) begin
                r_rw      <= i_rw;
                r_address <= i_address;
                r_wdata   <= i_wdata;
                r_sel     <= w_sel;
            end
            if (r_state == S_ACTIVE && w_sel_rdy) begin
                r_rdata <= w_s_rdata[r_sel];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_error_address <= '0;
            r_error_count   <= '0;
        end else if (r_state == S_ERROR) begin
            r_error_address <= r_address;
            if (r_error_count != 16'hFFFF) begin
                r_error_count <= r_error_count + 16'd1;
            end
        end
    end

    // Decoded from the state register so an async reset drops the slave request at once.
    always_comb begin
        o_s_request = '0;
        if (r_state == S_ACTIVE) begin
            o_s_request[r_sel] = 1'b1;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (r_state)
            S_DONE:  o_rdata = r_rdata;
            S_ERROR: o_rdata = ERROR_DATA;
            default: o_rdata = '0;
        endcase
    end

    assign o_ready         = (r_state == S_DONE) || (r_state == S_ERROR);
    assign o_error         = (r_state == S_ERROR);
    assign o_s_rw          = r_rw;
    assign o_s_address     = r_address & ADDR_MASK;
    assign o_s_wdata       = r_wdata;
    assign o_error_address = r_error_address;
    assign o_error_count   = r_error_count;

endmodule

// File: tb/tb_bus_slave_decoder.sv
// Directed bench for bus_slave_decoder: mapped/unmapped accesses, held requests, async reset abort, stall/timeout.
module tb_bus_slave_decoder;

    logic          i_clock;
    logic          i_reset;
    logic          i_request;
    logic          i_rw;
    logic [31:0]   i_address;
    logic [31:0]   i_wdata;
    logic [31:0]   o_rdata;
    logic          o_ready;
    logic          o_error;
    logic [3:0]    o_s_request;
    logic          o_s_rw;
    logic [31:0]   o_s_address;
    logic [31:0]   o_s_wdata;
    logic [127:0]  i_s_rdata;
    logic [3:0]    i_s_ready;
    logic [31:0]   o_error_address;
    logic [15:0]   o_error_count;

    int n_cmp;
    int n_err;
    int n_rdy;
    int n_req;
    int got;
    logic        e_seen;
    logic [31:0] d_seen;

    bus_slave_decoder #(
        .SLAVES      (4),
        .DECODE_BITS (4),
        .MAP         (16'h4310),
`ifdef BUS_DECODER_TIMEOUT_EN
        .TIMEOUT     (8),
`endif
        .ERROR_DATA  (32'hDEADBEEF)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_request       (i_request),
        .i_rw            (i_rw),
        .i_address       (i_address),
        .i_wdata         (i_wdata),
        .o_rdata         (o_rdata),
        .o_ready         (o_ready),
        .o_error         (o_error),
        .o_s_request     (o_s_request),
        .o_s_rw          (o_s_rw),
        .o_s_address     (o_s_address),
        .o_s_wdata       (o_s_wdata),
        .i_s_rdata       (i_s_rdata),
        .i_s_ready       (i_s_ready),
        .o_error_address (o_error_address),
        .o_error_count   (o_error_count)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        i_reset   = 1'b0;
        i_request = 1'b0;
        i_rw      = 1'b0;
        i_address = '0;
        i_wdata   = '0;
        i_s_rdata = '0;
        i_s_ready = '0;

        // Reset state
        repeat (2) @(negedge i_clock);
        check("rst_ready",   32'(o_ready), 32'd0);
        check("rst_error",   32'(o_error), 32'd0);
        check("rst_sreq",    32'(o_s_request), 32'd0);
        check("rst_rdata",   o_rdata, 32'd0);
        check("rst_saddr",   o_s_address, 32'd0);
        check("rst_errcnt",  32'(o_error_count), 32'd0);
        check("rst_erraddr", o_error_address, 32'd0);
        i_reset = 1'b1;
        @(negedge i_clock);

        // Read 0x1000_0010 from slave 1, ready 3 cycles after the request, stray ready from slave 0
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = 32'h1000_0010;
        i_wdata   = 32'hFFFF_FFFF;
        @(negedge i_clock);
        check("t1_sreq_c1", 32'(o_s_request), 32'h2);
        check("t1_saddr",   o_s_address, 32'h0000_0010);
        check("t1_srw",     32'(o_s_rw), 32'd0);
        check("t1_rdy_c1",  32'(o_ready), 32'd0);
        i_s_ready       = 4'b0001;
        i_s_rdata[31:0] = 32'hBAD0_0000;
        i_address       = 32'h7777_7777;
        @(negedge i_clock);
        check("t1_sreq_c2", 32'(o_s_request), 32'h2);
        check("t1_rdy_c2",  32'(o_ready), 32'd0);
        check("t1_saddr_c2", o_s_address, 32'h0000_0010);
        i_s_ready = 4'b0000;
        i_address = 32'h1000_0010;
        @(negedge i_clock);
        check("t1_sreq_c3", 32'(o_s_request), 32'h2);
        check("t1_rdy_c3",  32'(o_ready), 32'd0);
        @(negedge i_clock);
        check("t1_sreq_c4", 32'(o_s_request), 32'h2);
        i_s_ready        = 4'b0010;
        i_s_rdata[63:32] = 32'h1234_5678;
        @(negedge i_clock);
        check("t1_rdy_c5",  32'(o_ready), 32'd1);
        check("t1_err_c5",  32'(o_error), 32'd0);
        check("t1_rdata",   o_rdata, 32'h1234_5678);
        check("t1_sreq_c5", 32'(o_s_request), 32'd0);
        i_request = 1'b0;
        i_s_ready = 4'b0000;
        @(negedge i_clock);
        check("t1_rdy_c6",  32'(o_ready), 32'd0);
        @(negedge i_clock);

        // Write 0x3000_0000 = 0x41 to zero-wait slave 2
        i_s_ready        = 4'b0100;
        i_s_rdata[95:64] = 32'hA5A5_0002;
        i_request        = 1'b1;
        i_rw             = 1'b1;
        i_address        = 32'h3000_0000;
        i_wdata          = 32'h0000_0041;
        @(negedge i_clock);
        check("t2_sreq",   32'(o_s_request), 32'h4);
        check("t2_swdata", o_s_wdata, 32'h0000_0041);
        check("t2_srw",    32'(o_s_rw), 32'd1);
        check("t2_saddr",  o_s_address, 32'd0);
        check("t2_rdy_c1", 32'(o_ready), 32'd0);
        @(negedge i_clock);
        check("t2_rdy_c2", 32'(o_ready), 32'd1);
        check("t2_err_c2", 32'(o_error), 32'd0);
        check("t2_rdata",  o_rdata, 32'hA5A5_0002);
        i_request = 1'b0;
        i_s_ready = 4'b0000;
        repeat (2) @(negedge i_clock);

        // Unmapped read 0x7000_0004 with the request held 5 cycles past completion
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = 32'h7000_0004;
        @(negedge i_clock);
        check("t3_rdy_c1",  32'(o_ready), 32'd1);
        check("t3_err_c1",  32'(o_error), 32'd1);
        check("t3_rdata",   o_rdata, 32'hDEAD_BEEF);
        check("t3_sreq",    32'(o_s_request), 32'd0);
        n_rdy = 0;
        n_req = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clock);
            if (o_ready) n_rdy++;
            if (o_s_request != 4'b0000) n_req++;
            if (c == 0) begin
                check("t3_erraddr", o_error_address, 32'h7000_0004);
                check("t3_errcnt",  32'(o_error_count), 32'd1);
            end
        end
        check("t3_extra_rdy", 32'(n_rdy), 32'd0);
        check("t3_extra_req", 32'(n_req), 32'd0);
        i_request = 1'b0;
        repeat (2) @(negedge i_clock);

        // Mapped zero-wait read of slave 0 with the request held long after completion
        i_s_ready       = 4'b0001;
        i_s_rdata[31:0] = 32'h0000_0100;
        i_request       = 1'b1;
        i_address       = 32'h0000_0100;
        n_rdy = 0;
        n_req = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clock);
            if (o_ready) begin
                n_rdy++;
                check("t4_rdata", o_rdata, 32'h0000_0100);
            end
            if (o_s_request != 4'b0000) n_req++;
        end
        check("t4_one_rdy", 32'(n_rdy), 32'd1);
        check("t4_one_req", 32'(n_req), 32'd1);
        i_request = 1'b0;
        i_s_ready = 4'b0000;
        repeat (2) @(negedge i_clock);

        // Async reset while slave 3 is being accessed
        i_request = 1'b1;
        i_address = 32'h4000_0008;
        @(negedge i_clock);
        check("t5_sreq", 32'(o_s_request), 32'h8);
        #2 i_reset = 1'b0;
        #1;
        check("t5_sreq_async", 32'(o_s_request), 32'd0);
        @(negedge i_clock);
        check("t5_rdy_rst",    32'(o_ready), 32'd0);
        check("t5_sreq_rst",   32'(o_s_request), 32'd0);
        check("t5_errcnt_rst", 32'(o_error_count), 32'd0);
        i_request = 1'b0;
        i_reset   = 1'b1;
        @(negedge i_clock);
        i_s_ready         = 4'b1000;
        i_s_rdata[127:96] = 32'hC0FF_EE03;
        i_request         = 1'b1;
        @(negedge i_clock);
        check("t5_sreq_again", 32'(o_s_request), 32'h8);
        check("t5_saddr",      o_s_address, 32'h0000_0008);
        @(negedge i_clock);
        check("t5_rdy_again",  32'(o_ready), 32'd1);
        check("t5_rdata",      o_rdata, 32'hC0FF_EE03);
        i_request = 1'b0;
        i_s_ready = 4'b0000;
        repeat (2) @(negedge i_clock);

        // Stalled slave 0
        i_request = 1'b1;
        i_address = 32'h0000_0020;
        n_req  = 0;
        got    = 0;
        e_seen = 1'b0;
        d_seen = '0;
`ifdef BUS_DECODER_TIMEOUT_EN
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge i_clock);
            if (o_ready) begin
                got    = 1;
                e_seen = o_error;
                d_seen = o_rdata;
            end else if (o_s_request == 4'b0001) begin
                n_req++;
            end
        end
        check("t6_abort_seen", 32'(got), 32'd1);
        check("t6_req_cycles", 32'(n_req), 32'd8);
        check("t6_abort_err",  32'(e_seen), 32'd1);
        check("t6_abort_data", d_seen, 32'hDEAD_BEEF);
        i_request = 1'b0;
        @(negedge i_clock);
        check("t6_errcnt",  32'(o_error_count), 32'd1);
        check("t6_erraddr", o_error_address, 32'h0000_0020);
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clock);
            if (o_ready) got++;
            if (o_s_request == 4'b0001) n_req++;
        end
        check("t6_no_abort",   32'(got), 32'd0);
        check("t6_req_cycles", 32'(n_req), 32'd20);
        i_s_ready       = 4'b0001;
        i_s_rdata[31:0] = 32'h5A5A_0020;
        @(negedge i_clock);
        check("t6_rdy",   32'(o_ready), 32'd1);
        check("t6_err",   32'(o_error), 32'd0);
        check("t6_rdata", o_rdata, 32'h5A5A_0020);
        i_request = 1'b0;
        i_s_ready = 4'b0000;
        @(negedge i_clock);
        check("t6_errcnt", 32'(o_error_count), 32'd0);
`endif
        repeat (2) @(negedge i_clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
